// File: rtl/frame_color_analyzer_pkg.sv
// Shared definitions for the frame colour analyzer: FSM encoding, colour codes
// and the default camera geometry.
package frame_color_analyzer_pkg;

  localparam int         DEF_SCREEN_X = 160;
  localparam int         DEF_SCREEN_Y = 120;
  localparam int         DEF_AW       = 15;
  localparam int         DEF_DW       = 12;
  localparam logic [3:0] DEF_TH       = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'd0,
    COLOR_RED   = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_BLUE  = 2'd3
  } color_t;

endpackage

// File: rtl/frame_color_analyzer_pixel_classifier.sv
// Combinational RGB444 pixel classifier: a component wins only if it is a
// strict maximum and reaches the threshold.
module pixel_classifier
  import frame_color_analyzer_pkg::*;
(
  input  logic [11:0] pixel,
  input  logic [3:0]  th,
  output color_t      cls
);

  logic [3:0] r, g, b;

  assign r = pixel[11:8];
  assign g = pixel[7:4];
  assign b = pixel[3:0];

  always_comb begin
    cls = COLOR_NONE;
    if (r >= th && r > g && r > b)
      cls = COLOR_RED;
    else if (g >= th && g > r && g > b)
      cls = COLOR_GREEN;
    else if (b >= th && b > r && b > g)
      cls = COLOR_BLUE;
  end

endmodule

// File: rtl/frame_color_analyzer.sv
// Scans one frame from the frame buffer in raster order, counts pixels per
// dominant colour class and reports the winning class with its bounding box.
module frame_color_analyzer
  import frame_color_analyzer_pkg::*;
#(
  parameter int         CAM_SCREEN_X = DEF_SCREEN_X,
  parameter int         CAM_SCREEN_Y = DEF_SCREEN_Y,
  parameter int         AW           = DEF_AW,
  parameter int         DW           = DEF_DW,
  parameter logic [3:0] TH           = DEF_TH
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic [1:0]    color,
  output logic [AW-1:0] cnt_r,
  output logic [AW-1:0] cnt_g,
  output logic [AW-1:0] cnt_b,
  output logic [7:0]    x_min,
  output logic [7:0]    x_max,
  output logic [6:0]    y_min,
  output logic [6:0]    y_max
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(CAM_SCREEN_X * CAM_SCREEN_Y - 1);
  localparam logic [7:0]    X_LAST    = 8'(CAM_SCREEN_X - 1);
  localparam logic [6:0]    Y_LAST    = 7'(CAM_SCREEN_Y - 1);

  state_t        state, state_nxt;
  logic [7:0]    x, x_d;
  logic [6:0]    y, y_d;
  logic          pix_valid;
  logic          clear;
  color_t        cls, sel;

  // Per-class accumulators indexed by colour code; entry 0 (none) is unused.
  logic [AW-1:0] acc_cnt  [4];
  logic [7:0]    acc_xmin [4];
  logic [7:0]    acc_xmax [4];
  logic [6:0]    acc_ymin [4];
  logic [6:0]    acc_ymax [4];
  logic [AW-1:0] nxt_cnt  [4];
  logic [7:0]    nxt_xmin [4];
  logic [7:0]    nxt_xmax [4];
  logic [6:0]    nxt_ymin [4];
  logic [6:0]    nxt_ymax [4];

  pixel_classifier u_classifier (
    .pixel (mem_data[11:0]),
    .th    (TH),
    .cls   (cls)
  );

  assign clear = (state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SCAN;
      ST_SCAN:  if (mem_addr == LAST_ADDR) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      x         <= '0;
      y         <= '0;
      x_d       <= '0;
      y_d       <= '0;
      pix_valid <= 1'b0;
    end else begin
      // Coordinates trail the address by one cycle to line up with mem_data.
      pix_valid <= (state == ST_SCAN);
      x_d       <= x;
      y_d       <= y;
      if (clear) begin
        mem_addr <= '0;
        x        <= '0;
        y        <= '0;
      end else if (state == ST_SCAN && mem_addr != LAST_ADDR) begin
        mem_addr <= mem_addr + AW'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 7'd1;
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nxt_cnt[i]  = acc_cnt[i];
      nxt_xmin[i] = acc_xmin[i];
      nxt_xmax[i] = acc_xmax[i];
      nxt_ymin[i] = acc_ymin[i];
      nxt_ymax[i] = acc_ymax[i];
    end
    if (pix_valid && cls != COLOR_NONE) begin
      nxt_cnt[cls] = acc_cnt[cls] + AW'(1);
      if (x_d < acc_xmin[cls]) nxt_xmin[cls] = x_d;
      if (x_d > acc_xmax[cls]) nxt_xmax[cls] = x_d;
      if (y_d < acc_ymin[cls]) nxt_ymin[cls] = y_d;
      if (y_d > acc_ymax[cls]) nxt_ymax[cls] = y_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        acc_cnt[i]  <= '0;
        acc_xmin[i] <= X_LAST;
        acc_xmax[i] <= '0;
        acc_ymin[i] <= Y_LAST;
        acc_ymax[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clear) begin
          acc_cnt[i]  <= '0;
          acc_xmin[i] <= X_LAST;
          acc_xmax[i] <= '0;
          acc_ymin[i] <= Y_LAST;
          acc_ymax[i] <= '0;
        end else begin
          acc_cnt[i]  <= nxt_cnt[i];
          acc_xmin[i] <= nxt_xmin[i];
          acc_xmax[i] <= nxt_xmax[i];
          acc_ymin[i] <= nxt_ymin[i];
          acc_ymax[i] <= nxt_ymax[i];
        end
      end
    end
  end

  // Winner is chosen from the next-state counts so that the last pixel,
  // classified during FLUSH, is included when results load on entry to DONE.
  always_comb begin
    sel = COLOR_NONE;
    if (nxt_cnt[COLOR_RED] != '0 && nxt_cnt[COLOR_RED] >= nxt_cnt[COLOR_GREEN]
        && nxt_cnt[COLOR_RED] >= nxt_cnt[COLOR_BLUE])
      sel = COLOR_RED;
    else if (nxt_cnt[COLOR_GREEN] != '0 && nxt_cnt[COLOR_GREEN] >= nxt_cnt[COLOR_BLUE])
      sel = COLOR_GREEN;
    else if (nxt_cnt[COLOR_BLUE] != '0)
      sel = COLOR_BLUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color <= COLOR_NONE;
      cnt_r <= '0;
      cnt_g <= '0;
      cnt_b <= '0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
    end else if (state == ST_FLUSH) begin
      color <= sel;
      cnt_r <= nxt_cnt[COLOR_RED];
      cnt_g <= nxt_cnt[COLOR_GREEN];
      cnt_b <= nxt_cnt[COLOR_BLUE];
      if (sel == COLOR_NONE) begin
        x_min <= '0;
        x_max <= '0;
        y_min <= '0;
        y_max <= '0;
      end else begin
        x_min <= nxt_xmin[sel];
        x_max <= nxt_xmax[sel];
        y_min <= nxt_ymin[sel];
        y_max <= nxt_ymax[sel];
      end
    end
  end

endmodule

// File: tb/tb_frame_color_analyzer.sv
// Scoreboard bench for frame_color_analyzer: directed frames with hand-computed
// results, checked by a monitor whenever done pulses.
module tb_frame_color_analyzer;

  localparam int NPIX = 160 * 120;

  typedef struct {
    int cr, cg, cb, col, x0, x1, y0, y1, start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [14:0] mem_addr;
  logic [11:0] mem_data;
  logic        busy, done;
  logic [1:0]  color;
  logic [14:0] cnt_r, cnt_g, cnt_b;
  logic [7:0]  x_min, x_max;
  logic [6:0]  y_min, y_max;

  logic [11:0] fb [NPIX];
  exp_t        sb_q [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          addr_err = 0;
  int          prev_addr = 0;
  logic        prev_busy = 1'b0;

  frame_color_analyzer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .color    (color),
    .cnt_r    (cnt_r),
    .cnt_g    (cnt_g),
    .cnt_b    (cnt_b),
    .x_min    (x_min),
    .x_max    (x_max),
    .y_min    (y_min),
    .y_max    (y_max)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    mem_data <= fb[int'(mem_addr) % NPIX];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Address sequence watcher: starts at 0, then +1 or hold, never past the frame.
  always @(negedge clk) begin
    if (busy) begin
      if (!prev_busy) begin
        if (mem_addr != 15'd0) addr_err++;
      end else if (int'(mem_addr) != prev_addr && int'(mem_addr) != prev_addr + 1) begin
        addr_err++;
      end
      if (int'(mem_addr) >= NPIX) addr_err++;
    end
    prev_busy = busy;
    prev_addr = int'(mem_addr);
  end

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("latency", cyc - e.start_cyc, NPIX + 2);
        chk("color", int'(color), e.col);
        chk("cnt_r", int'(cnt_r), e.cr);
        chk("cnt_g", int'(cnt_g), e.cg);
        chk("cnt_b", int'(cnt_b), e.cb);
        chk("x_min", int'(x_min), e.x0);
        chk("x_max", int'(x_max), e.x1);
        chk("y_min", int'(y_min), e.y0);
        chk("y_max", int'(y_max), e.y1);
        chk("addr_seq_errs", addr_err, 0);
        chk("last_addr", int'(mem_addr), NPIX - 1);
      end
    end
  end

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < NPIX; i++) fb[i] = v;
  endtask

  task automatic set_px(input int x, input int y, input logic [11:0] v);
    fb[x + y * 160] = v;
  endtask

  function automatic exp_t mk(input int cr, cg, cb, col, x0, x1, y0, y1);
    exp_t e;
    e.cr = cr; e.cg = cg; e.cb = cb; e.col = col;
    e.x0 = x0; e.x1 = x1; e.y0 = y0; e.y1 = y1;
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic run_frame(input exp_t e, input bit repulse);
    int n;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    addr_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
      if (repulse && (n == 100 || n == 10000)) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_color"}, int'(color), 0);
    chk({tag, "_cnts"}, int'(cnt_r) + int'(cnt_g) + int'(cnt_b), 0);
    chk({tag, "_bbox"}, int'(x_min) + int'(x_max) + int'(y_min) + int'(y_max), 0);
  endtask

  initial begin
    exp_t last;
    fill(12'h000);
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Solid red frame
    fill(12'hF00);
    run_frame(mk(NPIX, 0, 0, 1, 0, 159, 0, 119), 1'b0);

    // Solid black frame
    fill(12'h000);
    run_frame(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Green block on a sub-threshold grey background
    fill(12'h111);
    for (int yy = 5; yy <= 24; yy++)
      for (int xx = 10; xx <= 19; xx++) set_px(xx, yy, 12'h0F0);
    run_frame(mk(0, 200, 0, 2, 10, 19, 5, 24), 1'b0);

    // Equal red and blue counts: red wins the tie
    fill(12'h000);
    for (int i = 0; i < 100; i++) fb[i] = 12'hF00;
    for (int i = 200; i < 300; i++) fb[i] = 12'h00F;
    run_frame(mk(100, 0, 100, 1, 0, 99, 0, 0), 1'b0);

    // Reset in the middle of a scan: results clear, no done
    fill(12'hF00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    @(negedge clk);

    // Corner pixels and threshold edges, started right after reset release
    fill(12'h000);
    set_px(0, 0, 12'h00F);
    set_px(159, 119, 12'h00F);
    set_px(50, 50, 12'h087);
    set_px(60, 60, 12'h077);
    set_px(70, 70, 12'h700);
    set_px(80, 80, 12'h800);
    rst = 1'b0;
    run_frame(mk(1, 1, 2, 3, 0, 159, 0, 119), 1'b0);

    // start re-pulsed during the scan is ignored
    fill(12'h111);
    for (int yy = 5; yy <= 24; yy++)
      for (int xx = 10; xx <= 19; xx++) set_px(xx, yy, 12'h0F0);
    last = mk(0, 200, 0, 2, 10, 19, 5, 24);
    run_frame(last, 1'b1);

    repeat (50) @(negedge clk);
    chk("done_pulses", done_count, 6);
    chk("queue_empty", sb_q.size(), 0);
    chk("hold_color", int'(color), last.col);
    chk("hold_cnt_g", int'(cnt_g), last.cg);
    chk("hold_bbox", {24'd0, x_min}, last.x0);
    chk("idle_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_color_analyzer.md
FRAME_COLOR_ANALYZER -- requirements
Module: frame_color_analyzer

Interface
REQ-001 SHALL have parameter CAM_SCREEN_X, default 160, frame width in pixels.
REQ-002 SHALL have parameter CAM_SCREEN_Y, default 120, frame height in pixels.
REQ-003 SHALL have parameter AW, default 15, frame-buffer address width.
REQ-004 SHALL have parameter DW, default 12, pixel width, RGB444 with R=[11:8], G=[7:4], B=[3:0].
REQ-005 SHALL have parameter TH, default 4'd8, minimum dominant-component value.
REQ-006 SHALL have port clk, input, 1, the single clock, which also clocks the frame buffer read port.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port start, input, 1, single-cycle request to analyse one frame.
REQ-009 SHALL have port mem_addr, output, AW, frame-buffer read address.
REQ-010 SHALL have port mem_data, input, DW, read data valid one clk after the address.
REQ-011 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when results are updated.
REQ-013 SHALL have port color, output, 2, dominant color: 0 none, 1 red, 2 green, 3 blue.
REQ-014 SHALL have ports cnt_r, cnt_g, cnt_b, output, AW each, per-class pixel counts.
REQ-015 SHALL have ports x_min, x_max, output, 8 each, and y_min, y_max, output, 7 each, giving the bounding box of the dominant class.

Function
REQ-016 SHALL implement the states IDLE, SCAN, FLUSH and DONE.
REQ-017 SHALL move from IDLE to SCAN on start=1, clear its internal accumulators and drive mem_addr=0 in the first SCAN cycle.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 SHALL, in SCAN, increment mem_addr by 1 each cycle, raster order, addr = x + y*CAM_SCREEN_X.
REQ-020 SHALL track x and y with counters, not a divider: x wraps at CAM_SCREEN_X-1 and y then increments.
REQ-021 SHALL go to FLUSH after issuing address CAM_SCREEN_X*CAM_SCREEN_Y-1 (19199) and never issue address 19200.
REQ-022 SHALL delay x, y and a valid flag by one stage so that they align with mem_data.
REQ-023 SHALL use FLUSH (1 cycle) to classify the last pixel, then enter DONE.
REQ-024 SHALL classify a pixel red if R>=TH and R>G and R>B, with green and blue classified likewise; any tie or max<TH gives no class.
REQ-025 SHALL increment the class counter and update that class's min/max x/y for each classified pixel, and SHALL initialise each bbox to min=max-coordinate, max=0.
REQ-026 SHALL, in DONE, select color as the class with the largest count, tie priority red>green>blue, and color=0 when all counts are 0.
REQ-027 SHALL, in DONE, register all result outputs, pulse done for exactly 1 cycle, then return to IDLE.
REQ-028 SHALL force the bbox outputs to x_min=0, x_max=0, y_min=0, y_max=0 when color=0.
REQ-029 SHALL keep result outputs stable from DONE until the next DONE.
REQ-030 SHALL hold busy high in SCAN, FLUSH and DONE, and low in IDLE.
REQ-031 SHALL take exactly CAM_SCREEN_X*CAM_SCREEN_Y + 2 cycles from the cycle after start is sampled to the done pulse (19202 by default).
REQ-032 SHALL keep counters at AW bits without saturation; the maximum count of 19200 fits in 15 bits.

Reset
REQ-033 SHALL, on rst, return asynchronously to IDLE with mem_addr=0, busy=0, done=0, color=0, all counts 0 and all bbox outputs 0.
REQ-034 SHALL abandon a scan interrupted by rst mid-frame, update no results, and accept start on the first clock after rst is released.

Structure
REQ-035 SHALL place the state encoding, the color codes (NONE/RED/GREEN/BLUE) and the default frame geometry in a shared package with the camera constants.
REQ-036 SHALL put per-pixel classification in one combinational sub-module, pixel_classifier (input RGB444 and TH, output 2-bit class).

Verification
REQ-037 SHALL cover an all-0xF00 frame, start: cnt_r=19200, color=1, bbox (0,159,0,119), and done exactly 19202 cycles after start.
REQ-038 SHALL cover an all-0x000 frame: all counts 0, color=0, bbox all 0.
REQ-039 SHALL cover a 0x0F0 block at x=10..19, y=5..24 on a 0x111 background: cnt_g=200, color=2, bbox (10,19,5,24).
REQ-040 SHALL cover 100 pixels of 0xF00 plus 100 pixels of 0x00F: color=1 (tie priority), cnt_b=100.
REQ-041 SHALL cover rst asserted at scan cycle 5000, then a new start: previous results hold 0, and the new scan completes normally.
REQ-042 SHALL cover start re-pulsed during SCAN: it is ignored, there is a single done pulse, and the address sequence is unbroken 0..19199.
